// File: rtl/ram_sweep_pkg.sv
// Shared state type, constants and parity helper for the sweep-cleared RAM.
// Parity storage is enabled by defining MEM_PARITY_EN.
package ram_sweep_pkg;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } ram_state_e;

  localparam int RSP_LAT   = 1;
  localparam int PAR_MAX_W = 64;

  // Words are zero-extended to PAR_MAX_W, which leaves their parity unchanged.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Bare storage array: one write port, one registered read port, no reset.
// Contents are only meaningful after the controller's clear sweep.
module ram_sp_core #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_sweep_ctrl.sv
// Single-port RAM with valid/ready requests, 1-cycle read response and a
// word-per-cycle clear sweep after reset or clr. Optional parity: MEM_PARITY_EN.
module ram_sweep_ctrl
  import ram_sweep_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              par_inj,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              addr_err,
  output logic              par_err,
  output logic              busy
);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  ram_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic              addr_err_q;
  logic              rdata_zero_q;

  logic              clearing;
  logic              in_range;
  logic              req_fire;
  logic              rd_fire;
  logic              core_wr_en;
  logic              core_rd_en;
  logic [ADDR_W-1:0] core_wr_addr;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  assign clearing = (state_q == S_CLEAR);
  // Widened compare so a power-of-two DEPTH does not truncate to zero.
  assign in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
  assign req_fire = req_valid & req_ready_q;
  assign rd_fire  = req_fire & ~req_we;

  assign core_wr_en   = clearing | (req_fire & req_we & in_range);
  assign core_wr_addr = clearing ? cnt_q : req_addr;
  assign core_rd_en   = rd_fire & in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      req_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        S_RUN: begin
          if (clr) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_CLEAR;
          cnt_q       <= '0;
          busy_q      <= 1'b1;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range reads still respond; rdata_zero_q masks the stale core word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else begin
      rsp_valid_q <= rd_fire;
      addr_err_q  <= req_fire & ~in_range;
      if (rd_fire) begin
        rdata_zero_q <= ~in_range;
      end
    end
  end

`ifdef MEM_PARITY_EN
  assign wr_word = clearing ? '0
                 : {even_parity(PAR_MAX_W'(req_wdata)) ^ par_inj, req_wdata};
  assign par_err = rsp_valid_q & ~rdata_zero_q
                 & (even_parity(PAR_MAX_W'(rd_word[DATA_W-1:0])) ^ rd_word[DATA_W]);
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign wr_word = clearing ? '0 : req_wdata;
  assign par_err = 1'b0;
`endif

  ram_sp_core #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .wr_en   (core_wr_en),
    .wr_addr (core_wr_addr),
    .wr_data (wr_word),
    .rd_en   (core_rd_en),
    .rd_addr (req_addr),
    .rd_data (rd_word)
  );

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign addr_err  = addr_err_q;
  assign rsp_rdata = rdata_zero_q ? '0 : rd_word[DATA_W-1:0];

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Randomized + directed bench for ram_sweep_ctrl (DEPTH=6) against a behavioural model.
// Parity expectations follow MEM_PARITY_EN when it is defined.
module tb_ram_sweep_ctrl;
  import ram_sweep_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 6;
  localparam int AW    = $clog2(DEPTH);
  localparam int INF   = 32'h3fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          par_inj = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          addr_err;
  logic          par_err;
  logic          busy;

  ram_sweep_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .par_inj   (par_inj),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .addr_err  (addr_err),
    .par_err   (par_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: ready once the edge count reaches ready_at; contents as plain arrays.
  int            cyc = 0;
  int            ready_at = INF;
  logic [DW-1:0] mem_m [DEPTH];
  bit            pbad_m [DEPTH];
  logic          exp_rv, exp_ae, exp_pe, exp_ready, exp_busy;
  logic [DW-1:0] exp_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_rv = 1'b0; exp_ae = 1'b0; exp_pe = 1'b0; exp_rd = '0;
    ready_at = INF;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      pbad_m[i] = 1'b0;
    end
  endtask

  task automatic step(input bit arst = 1'b0);
    bit fire;
    int a;
    @(posedge clk);
    if (!rst_n) begin
      cyc++;
      model_reset();
    end else begin
      fire = req_valid && (cyc >= ready_at);
      cyc++;
      exp_rv = 1'b0; exp_ae = 1'b0; exp_pe = 1'b0;
      if (fire) begin
        a = int'(req_addr);
        if (a >= DEPTH) begin
          exp_ae = 1'b1;
          if (!req_we) begin
            exp_rv = 1'b1;
            exp_rd = '0;
          end
        end else if (req_we) begin
          mem_m[a] = req_wdata;
`ifdef MEM_PARITY_EN
          pbad_m[a] = par_inj;
`endif
        end else begin
          exp_rv = 1'b1;
          exp_rd = mem_m[a];
          exp_pe = pbad_m[a];
        end
        $display("txn cyc=%0d %s addr=%0d wdata=%02h inj=%0d clr=%0d", cyc,
                 req_we ? "WR" : "RD", a, req_wdata, par_inj, clr);
      end
      if (clr) begin
        ready_at = cyc + DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
          mem_m[i] = '0;
          pbad_m[i] = 1'b0;
        end
      end
    end
    if (arst) begin
      rst_n = 1'b0;
      model_reset();
    end
    exp_ready = rst_n && (cyc >= ready_at);
    exp_busy  = !exp_ready;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("addr_err", 32'(addr_err), 32'(exp_ae));
    chk("par_err", 32'(par_err), 32'(exp_pe));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
  endtask

  task automatic txn(input bit v, input bit we, input int addr, input logic [DW-1:0] d,
                     input bit inj, input bit cl, input bit arst = 1'b0);
    req_valid = v; req_we = we; req_addr = AW'(addr); req_wdata = d;
    par_inj = inj; clr = cl;
    step(arst);
    req_valid = 1'b0; req_we = 1'b0; par_inj = 1'b0; clr = 1'b0;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    ready_at = cyc + DEPTH;
  endtask

  // Counts edges until req_ready is seen; a clear must take exactly 6 edges.
  task automatic wait_ready(input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= DEPTH + 4 && !seen; i++) begin
      step();
      if (req_ready === 1'b1) begin
        seen = 1'b1;
        n = i;
      end
    end
    chk(name, 32'(n), 32'd6);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) txn(1, 0, i, '0, 0, 0);
    txn(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    step();
    step();
    chk("reset_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    release_reset();
    wait_ready("ready_after_reset");
    read_all();

    // Write then immediate read of the same address.
    txn(1, 1, 3, 8'hA5, 0, 0);
    txn(1, 0, 3, '0, 0, 0);
    chk("a5_valid", 32'(rsp_valid), 32'd1);
    chk("a5_rdata", 32'(rsp_rdata), 32'hA5);
    chk("a5_par", 32'(par_err), 32'd0);
    txn(0, 0, 0, '0, 0, 0);
    chk("rdata_hold", 32'(rsp_rdata), 32'hA5);

    // Out-of-range write and read at address 7.
    for (int i = 0; i < DEPTH; i++) txn(1, 1, i, DW'($urandom), 0, 0);
    txn(1, 1, 7, 8'h5A, 0, 0);
    txn(1, 0, 7, '0, 0, 0);
    chk("oor_rd_err", 32'(addr_err), 32'd1);
    chk("oor_rd_data", 32'(rsp_rdata), 32'd0);
    read_all();

    // Fill with 0xFF, then two clr pulses three cycles apart.
    for (int i = 0; i < DEPTH; i++) txn(1, 1, i, 8'hFF, 0, 0);
    txn(0, 0, 0, '0, 0, 1);
    txn(0, 0, 0, '0, 0, 0);
    txn(0, 0, 0, '0, 0, 0);
    txn(0, 0, 0, '0, 0, 1);
    wait_ready("ready_after_clr");
    read_all();

`ifdef MEM_PARITY_EN
    txn(1, 1, 2, 8'h3C, 1, 0);
    txn(1, 0, 2, '0, 0, 0);
    chk("inj_rdata", 32'(rsp_rdata), 32'h3C);
    chk("inj_par_err", 32'(par_err), 32'd1);
    txn(1, 1, 2, 8'h3C, 0, 0);
    txn(1, 0, 2, '0, 0, 0);
    chk("clean_par_err", 32'(par_err), 32'd0);
`endif

    for (int n = 0; n < 500; n++) begin
      txn($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
          DW'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    end
    while (cyc < ready_at) txn(0, 0, 0, '0, 0, 0);

    // Reset asserted right after a read is accepted discards its response.
    txn(1, 1, 2, 8'h77, 0, 0);
    txn(1, 0, 2, '0, 0, 0, 1'b1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    step();
    step();
    release_reset();
    wait_ready("ready_after_rst");
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
